// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port round-robin front end for a single-port-per-direction RAM
// Zero-fills the RAM after reset, then issues one granted access per cycle and steers read data back.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1,
  parameter int INIT_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  init_done,
  output logic                  ram_wr_enb,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_enb,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // One extra counter bit so the last address compares cleanly instead of wrapping to 0.
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH:0]     init_cnt;
  logic                    last_gnt;
  logic                    rd_id;
  logic [RD_LAT-1:0]       pipe_v;
  logic [RD_LAT-1:0]       pipe_id;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      S_INIT: begin
        if (init_cnt == LAST_ADDR) state_nxt = S_RUN;
      end
      S_RUN: begin
        // On a tie the port that did not win last time gets the slot.
        if (req0 && req1) begin
          gnt0 = last_gnt;
          gnt1 = ~last_gnt;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  assign sel_we    = gnt1 ? we1    : we0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= (INIT_EN != 0) ? S_INIT : S_RUN;
      init_cnt    <= '0;
      last_gnt    <= 1'b1;
      rd_id       <= 1'b0;
      init_done   <= 1'b0;
      ram_wr_enb  <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_rd_enb  <= 1'b0;
      ram_rd_addr <= '0;
      pipe_v      <= '0;
      pipe_id     <= '0;
    end else begin
      state      <= state_nxt;
      ram_wr_enb <= 1'b0;
      ram_rd_enb <= 1'b0;
      if (state == S_INIT) begin
        ram_wr_enb  <= 1'b1;
        ram_wr_addr <= init_cnt[ADDR_WIDTH-1:0];
        ram_wr_data <= '0;
        init_cnt    <= init_cnt + (ADDR_WIDTH + 1)'(1);
      end else if (gnt0 || gnt1) begin
        last_gnt <= gnt1;
        if (sel_we) begin
          ram_wr_enb  <= 1'b1;
          ram_wr_addr <= sel_addr;
          ram_wr_data <= sel_wdata;
        end else begin
          ram_rd_enb  <= 1'b1;
          ram_rd_addr <= sel_addr;
          rd_id       <= gnt1;
        end
      end
      if (state_nxt == S_RUN) init_done <= 1'b1;
      // Tracks each issued read until its data emerges RD_LAT cycles later.
      pipe_v[0]  <= ram_rd_enb;
      pipe_id[0] <= rd_id;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign rvalid0 = pipe_v[RD_LAT-1] & ~pipe_id[RD_LAT-1];
  assign rvalid1 = pipe_v[RD_LAT-1] &  pipe_id[RD_LAT-1];
  assign rdata0  = ram_rd_data;
  assign rdata1  = ram_rd_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed bench for ram_port_arbiter
// Two instances (RD_LAT=1 and RD_LAT=3) share clock and reset, each backed by a behavioural RAM.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, init_done;
  logic [7:0] rdata0, rdata1;
  logic       ram_wr_enb, ram_rd_enb;
  logic [3:0] ram_wr_addr, ram_rd_addr;
  logic [7:0] ram_wr_data, ram_rd_data;
  logic [7:0] mem1 [16];

  logic       b_req0 = 1'b0, b_req1 = 1'b0, b_we0 = 1'b0, b_we1 = 1'b0;
  logic [3:0] b_addr0 = '0, b_addr1 = '0;
  logic [7:0] b_wdata0 = '0, b_wdata1 = '0;
  logic       b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_init_done;
  logic [7:0] b_rdata0, b_rdata1;
  logic       b_wr_enb, b_rd_enb;
  logic [3:0] b_wr_addr, b_rd_addr;
  logic [7:0] b_wr_data, b_rd_data, b_d1, b_d2;
  logic [7:0] mem3 [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LAT(1), .INIT_EN(1)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .init_done(init_done),
    .ram_wr_enb(ram_wr_enb), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_enb(ram_rd_enb), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  ram_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LAT(3), .INIT_EN(1)) dut3 (
    .clk(clk), .rst(rst), .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata0(b_rdata0), .rdata1(b_rdata1), .init_done(b_init_done),
    .ram_wr_enb(b_wr_enb), .ram_wr_addr(b_wr_addr), .ram_wr_data(b_wr_data),
    .ram_rd_enb(b_rd_enb), .ram_rd_addr(b_rd_addr), .ram_rd_data(b_rd_data)
  );

  always @(posedge clk) begin
    if (ram_wr_enb) mem1[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_enb) ram_rd_data <= mem1[ram_rd_addr];
  end

  always @(posedge clk) begin
    if (b_wr_enb) mem3[b_wr_addr] <= b_wr_data;
    if (b_rd_enb) b_d1 <= mem3[b_rd_addr];
    b_d2      <= b_d1;
    b_rd_data <= b_d2;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40 && !(init_done && b_init_done); i++) tick();
    n_checks++;
    if ((init_done & b_init_done) !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_init: init_done=%b/%b required 1/1", init_done, b_init_done);
    end
  endtask

  task automatic test_reset;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd0; wdata0 = 8'h00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (ram_wr_enb !== 1'b0) begin n_fail++; $display("FAIL rst_wr_enb: got %b required 0", ram_wr_enb); end
    n_checks++; if (ram_rd_enb !== 1'b0) begin n_fail++; $display("FAIL rst_rd_enb: got %b required 0", ram_rd_enb); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %b required 0", init_done); end
    n_checks++; if ((rvalid0 | rvalid1) !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b%b required 00", rvalid1, rvalid0); end
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++; if (ram_wr_enb !== 1'b1) begin n_fail++; $display("FAIL init_wr_enb[%0d]: got %b required 1", i, ram_wr_enb); end
      n_checks++; if (ram_wr_addr !== 4'(i)) begin n_fail++; $display("FAIL init_wr_addr[%0d]: got %0d required %0d", i, ram_wr_addr, i); end
      n_checks++; if (ram_wr_data !== 8'h00) begin n_fail++; $display("FAIL init_wr_data[%0d]: got %h required 00", i, ram_wr_data); end
      n_checks++; if (init_done !== (i == 15)) begin n_fail++; $display("FAIL init_done[%0d]: got %b required %b", i, init_done, i == 15); end
      if (i < 15) begin
        n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL init_gnt0[%0d]: got %b required 0", i, gnt0); end
      end else begin
        n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL run_gnt0: got %b required 1", gnt0); end
        req0 = 1'b0;
      end
    end
    tick();
    n_checks++; if (ram_wr_enb !== 1'b0) begin n_fail++; $display("FAIL post_init_wr_enb: got %b required 0", ram_wr_enb); end
    n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL post_init_done: got %b required 1", init_done); end
  endtask

  task automatic test_write_read;
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'hA5;
    #1;
    n_checks++; if ({gnt1, gnt0} !== 2'b01) begin n_fail++; $display("FAIL wr_gnt: got %b%b required 01", gnt1, gnt0); end
    tick();
    n_checks++; if ({ram_wr_enb, ram_rd_enb} !== 2'b10) begin n_fail++; $display("FAIL wr_enb: got wr=%b rd=%b required 1/0", ram_wr_enb, ram_rd_enb); end
    n_checks++; if ({ram_wr_addr, ram_wr_data} !== {4'd3, 8'hA5}) begin n_fail++; $display("FAIL wr_cmd: got %0d/%h required 3/a5", ram_wr_addr, ram_wr_data); end
    we0 = 1'b0;
    #1;
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b required 1", gnt0); end
    tick();
    req0 = 1'b0;
    n_checks++; if ({ram_rd_enb, ram_wr_enb} !== 2'b10) begin n_fail++; $display("FAIL rd_enb: got rd=%b wr=%b required 1/0", ram_rd_enb, ram_wr_enb); end
    n_checks++; if (ram_rd_addr !== 4'd3) begin n_fail++; $display("FAIL rd_addr: got %0d required 3", ram_rd_addr); end
    n_checks++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL rvalid0_early: got %b required 0", rvalid0); end
    tick();
    n_checks++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL rvalid0: got %b required 1", rvalid0); end
    n_checks++; if (rdata0 !== 8'hA5) begin n_fail++; $display("FAIL rdata0: got %h required a5", rdata0); end
    n_checks++; if (rvalid1 !== 1'b0) begin n_fail++; $display("FAIL rvalid1_quiet: got %b required 0", rvalid1); end
    tick();
    n_checks++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL rvalid0_pulse: got %b required 0", rvalid0); end
  endtask

  task automatic test_alternate;
    wait_init();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd1; wdata0 = 8'h11;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd2; wdata1 = 8'h22;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++; if ({gnt1, gnt0} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL alt_gnt[%0d]: got %b%b required %s", k, gnt1, gnt0, (k % 2 == 0) ? "01" : "10"); end
      tick();
      n_checks++; if ({ram_wr_enb, ram_wr_addr} !== ((k % 2 == 0) ? 5'b1_0001 : 5'b1_0010)) begin n_fail++; $display("FAIL alt_wr_addr[%0d]: got enb=%b addr=%0d required 1/%0d", k, ram_wr_enb, ram_wr_addr, (k % 2 == 0) ? 1 : 2); end
      n_checks++; if (ram_wr_data !== ((k % 2 == 0) ? 8'h11 : 8'h22)) begin n_fail++; $display("FAIL alt_wr_data[%0d]: got %h", k, ram_wr_data); end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_tie_raw;
    wait_init();
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd5;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd5; wdata1 = 8'h7E;
    #1;
    n_checks++; if ({gnt1, gnt0} !== 2'b01) begin n_fail++; $display("FAIL tie_gnt: got %b%b required 01", gnt1, gnt0); end
    tick();
    req0 = 1'b0;
    n_checks++; if ({ram_rd_enb, ram_rd_addr} !== 5'b1_0101) begin n_fail++; $display("FAIL tie_rd: got enb=%b addr=%0d required 1/5", ram_rd_enb, ram_rd_addr); end
    #1;
    n_checks++; if ({gnt1, gnt0} !== 2'b10) begin n_fail++; $display("FAIL tie_gnt1: got %b%b required 10", gnt1, gnt0); end
    tick();
    n_checks++; if ({ram_wr_enb, ram_wr_addr, ram_wr_data} !== {1'b1, 4'd5, 8'h7E}) begin n_fail++; $display("FAIL tie_wr: got %b/%0d/%h required 1/5/7e", ram_wr_enb, ram_wr_addr, ram_wr_data); end
    n_checks++; if ({rvalid0, rdata0} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL tie_old_data: got %b/%h required 1/00", rvalid0, rdata0); end
    req1 = 1'b0;
    req0 = 1'b1;
    #1;
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL raw_gnt0: got %b required 1", gnt0); end
    tick();
    req0 = 1'b0;
    tick();
    n_checks++; if ({rvalid0, rdata0} !== {1'b1, 8'h7E}) begin n_fail++; $display("FAIL raw_new_data: got %b/%h required 1/7e", rvalid0, rdata0); end
  endtask

  task automatic test_reset_mid_init;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_checks++; if (ram_wr_addr !== 4'd7) begin n_fail++; $display("FAIL mid_addr: got %0d required 7", ram_wr_addr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if ({ram_wr_enb, ram_rd_enb, init_done, gnt0, gnt1, rvalid0, rvalid1} !== 7'b0) begin n_fail++; $display("FAIL mid_rst_flags: got %b%b%b%b%b%b%b required 0000000", ram_wr_enb, ram_rd_enb, init_done, gnt0, gnt1, rvalid0, rvalid1); end
    n_checks++; if ({ram_wr_addr, ram_wr_data, ram_rd_addr} !== 16'h0) begin n_fail++; $display("FAIL mid_rst_bus: got %0d/%h/%0d required 0/00/0", ram_wr_addr, ram_wr_data, ram_rd_addr); end
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++; if ({ram_wr_enb, ram_wr_addr} !== {1'b1, 4'(i)}) begin n_fail++; $display("FAIL reinit_wr[%0d]: got %b/%0d required 1/%0d", i, ram_wr_enb, ram_wr_addr, i); end
    end
    tick();
    n_checks++; if ({ram_wr_enb, init_done} !== 2'b01) begin n_fail++; $display("FAIL reinit_done: got wr=%b done=%b required 0/1", ram_wr_enb, init_done); end
  endtask

  task automatic test_back_to_back;
    n_checks++; if (b_init_done !== 1'b1) begin n_fail++; $display("FAIL b2b_init_done: got %b required 1", b_init_done); end
    b_req1 = 1'b1; b_we1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_addr1 = 4'(i); b_wdata1 = 8'h30 + 8'(i);
      #1;
      n_checks++; if (b_gnt1 !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_gnt[%0d]: got %b required 1", i, b_gnt1); end
      tick();
    end
    b_we1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_addr1 = 4'(i);
      #1;
      n_checks++; if (b_gnt1 !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_gnt[%0d]: got %b required 1", i, b_gnt1); end
      n_checks++; if (b_rvalid1 !== 1'b0) begin n_fail++; $display("FAIL b2b_early[%0d]: got %b required 0", i, b_rvalid1); end
      tick();
    end
    b_req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({b_rvalid1, b_rdata1} !== {1'b1, 8'h30 + 8'(i)}) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %b/%h required 1/%h", i, b_rvalid1, b_rdata1, 8'h30 + 8'(i)); end
      n_checks++; if (b_rvalid0 !== 1'b0) begin n_fail++; $display("FAIL b2b_rvalid0[%0d]: got %b required 0", i, b_rvalid0); end
      tick();
    end
    n_checks++; if (b_rvalid1 !== 1'b0) begin n_fail++; $display("FAIL b2b_tail: got %b required 0", b_rvalid1); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_tie_raw();
    test_reset_mid_init();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
